// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port synchronous data RAM.
// Grants are combinational (same cycle as the request), read-valid is
// registered and steered back to the port that issued the read.
// Build option: define DMEM_ARB_RR_EN to replace the fixed-priority policy
// (port 0 highest, port 1 starvation counter) with 1-bit round-robin.

`ifndef ADDR_LEN
`define ADDR_LEN 32
`endif
`ifndef DATA_LEN
`define DATA_LEN 32
`endif

module dmem_arbiter #(
   parameter int MAX_WAIT = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 p0_req,
   input  logic                 p0_we,
   input  logic                 p0_lock,
   input  logic [`ADDR_LEN-1:0] p0_addr,
   input  logic [`DATA_LEN-1:0] p0_wdata,
   input  logic                 p1_req,
   input  logic                 p1_we,
   input  logic                 p1_lock,
   input  logic [`ADDR_LEN-1:0] p1_addr,
   input  logic [`DATA_LEN-1:0] p1_wdata,
   output logic                 p0_gnt,
   output logic                 p1_gnt,
   output logic                 p0_rvalid,
   output logic                 p1_rvalid,
   output logic [`DATA_LEN-1:0] p0_rdata,
   output logic [`DATA_LEN-1:0] p1_rdata,
   output logic [`ADDR_LEN-1:0] mem_addr,
   output logic [`DATA_LEN-1:0] mem_wdata,
   output logic                 mem_we,
   input  logic [`DATA_LEN-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   gnt0, gnt1;
   logic   arb_free;
   logic   rvalid0_q, rvalid0_d;
   logic   rvalid1_q, rvalid1_d;

`ifdef DMEM_ARB_RR_EN
   // Port that wins the next tie; it is always the port that was not granted last.
   logic   prio_q, prio_d;
`else
   localparam logic [7:0] MAX_WAIT_C = MAX_WAIT[7:0];
   logic [7:0] wait_q, wait_d;
`endif

   // Grant selection and next FSM state; a lock whose owner stops requesting
   // falls straight through to free arbitration in the same cycle.
   always_comb begin
      gnt0     = 1'b0;
      gnt1     = 1'b0;
      arb_free = 1'b0;
      state_d  = ARB;
      case (state_q)
         LOCK0: begin
            if (p0_req) gnt0 = 1'b1;
            else        arb_free = 1'b1;
         end
         LOCK1: begin
            if (p1_req) gnt1 = 1'b1;
            else        arb_free = 1'b1;
         end
         default: arb_free = 1'b1;
      endcase
      if (arb_free) begin
`ifdef DMEM_ARB_RR_EN
         if (p0_req && p1_req) begin
            gnt0 = ~prio_q;
            gnt1 = prio_q;
         end else begin
            gnt0 = p0_req;
            gnt1 = p1_req;
         end
`else
         if (p1_req && (!p0_req || (wait_q >= MAX_WAIT_C))) gnt1 = 1'b1;
         else if (p0_req)                                     gnt0 = 1'b1;
`endif
      end
      if (reset) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
      if (gnt0)      state_d = p0_lock ? LOCK0 : ARB;
      else if (gnt1) state_d = p1_lock ? LOCK1 : ARB;
      else           state_d = ARB;
   end

   // Policy bookkeeping: starvation counter for port 1, or round-robin priority.
   always_comb begin
`ifdef DMEM_ARB_RR_EN
      prio_d = prio_q;
      if (gnt0)      prio_d = 1'b1;
      else if (gnt1) prio_d = 1'b0;
`else
      wait_d = wait_q;
      if (gnt1)                           wait_d = 8'd0;
      else if (p1_req && wait_q != 8'hFF) wait_d = wait_q + 8'd1;
`endif
   end

   // Remember which port owns the read that returns next cycle.
   always_comb begin
      rvalid0_d = gnt0 & ~p0_we;
      rvalid1_d = gnt1 & ~p1_we;
   end

   // Registered state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ARB;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
`ifdef DMEM_ARB_RR_EN
         prio_q    <= 1'b0;
`else
         wait_q    <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
`ifdef DMEM_ARB_RR_EN
         prio_q    <= prio_d;
`else
         wait_q    <= wait_d;
`endif
      end
   end

   // RAM-side mux; idle cycles drive zeros, and reset masks any in-flight read.
   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_we    = 1'b0;
      if (gnt0) begin
         mem_addr  = p0_addr;
         mem_wdata = p0_wdata;
         mem_we    = p0_we;
      end else if (gnt1) begin
         mem_addr  = p1_addr;
         mem_wdata = p1_wdata;
         mem_we    = p1_we;
      end
      p0_gnt    = gnt0;
      p1_gnt    = gnt1;
      p0_rvalid = rvalid0_q & ~reset;
      p1_rvalid = rvalid1_q & ~reset;
      p0_rdata  = mem_rdata;
      p1_rdata  = mem_rdata;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MAX_WAIT, 8, number of consecutive cycles port 1 may be denied in fixed-priority mode before it is forced to win; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 p0_req / p1_req  input  1  access request; held with the port's addr, we and wdata stable until that port's gnt is seen.
REQ-005 p0_we / p1_we  input  1  1 = write, 0 = read.
REQ-006 p0_lock / p1_lock  input  1  keeps the grant on this port for the following cycles.
REQ-007 p0_addr / p1_addr  input  `ADDR_LEN  word address.
REQ-008 p0_wdata / p1_wdata  input  `DATA_LEN  write data.
REQ-009 p0_gnt / p1_gnt  output  1  access issued this cycle (combinational).
REQ-010 p0_rvalid / p1_rvalid  output  1  read data valid for this port (registered).
REQ-011 p0_rdata / p1_rdata  output  `DATA_LEN  read data; both ports are driven from mem_rdata.
REQ-012 mem_addr / mem_wdata  output  `ADDR_LEN / `DATA_LEN  to the single-port synchronous RAM; these are the selected port's values, or 0 when idle.
REQ-013 mem_we  output  1  RAM write enable; equals the granted port's we AND its gnt.
REQ-014 mem_rdata  input  `DATA_LEN  RAM read data, valid one cycle after the address is presented.

Function
REQ-015 The arbiter SHALL grant at most one port per cycle, and the grant SHALL be asserted only when that port's req is high.
REQ-016 FSM states SHALL be ARB, LOCK0 and LOCK1, with reset state ARB.
REQ-017 ARB: selection SHALL follow the policy in REQ-024/025. If the granted port has lock=1, next state is LOCKn; otherwise it stays ARB.
REQ-018 LOCKn: only port n SHALL be granted. The other port's req SHALL be ignored, and its wait counter SHALL increment.
REQ-019 LOCKn SHALL return to ARB on the first cycle that pn_req=0, or that pn_gnt=1 with pn_lock=0; no arbitration cycle is lost on that transition.
REQ-020 For a granted read in cycle T, pn_rvalid SHALL be 1 in cycle T+1 only; the other port's rvalid SHALL stay 0.
REQ-021 The read owner SHALL be registered so that back-to-back reads from alternating ports each return to the correct port.
REQ-022 A granted write SHALL never produce rvalid.
REQ-023 A read and a write in consecutive cycles to the same address SHALL see RAM read-before-write ordering unmodified; the arbiter adds no forwarding.
REQ-024 Default policy is fixed priority with port 0 highest. A wait counter (8 bits) SHALL count cycles with p1_req=1 and p1_gnt=0, and clear on p1_gnt.
REQ-025 When the wait counter reaches MAX_WAIT in ARB, port 1 SHALL win the next contest regardless of p0_req.
REQ-026 The arbiter SHALL add no latency: gnt is issued in the same cycle as req when the port wins.

Reset
REQ-027 While reset=1:
- FSM SHALL go to ARB.
- Wait counter and round-robin pointer SHALL clear to 0.
- All gnt, rvalid and mem_we outputs SHALL be 0 in that cycle.
REQ-028 A read granted in the cycle before reset asserts SHALL NOT produce rvalid.
REQ-029 After reset deasserts, an active lock SHALL be released.

Configuration
REQ-030 With macro DMEM_ARB_RR_EN defined, the arbiter SHALL use round-robin selection instead of REQ-024/025:
- A 1-bit last-grant pointer decides ties; the port not granted last wins.
- The pointer SHALL update on every ARB grant, and on the exit grant from a LOCK state.
- The wait counter and MAX_WAIT logic SHALL be omitted.
REQ-031 Without DMEM_ARB_RR_EN, the fixed-priority behaviour of REQ-024/025 SHALL apply.

Verification
REQ-032 p0 read addr 0x10 in cycle 1 with RAM word 0x10=0xDEADBEEF -> p0_gnt=1 in cycle 1; p0_rvalid=1 and p0_rdata=0xDEADBEEF in cycle 2; p1_rvalid=0.
REQ-033 p0_req and p1_req held high continuously, fixed mode, MAX_WAIT=8 -> p1_gnt first asserts in the 9th cycle; the counter then clears and the pattern repeats.
REQ-034 p1 read, then p0 read, then p1 write in cycles 1-3 -> p1_rvalid in cycle 2, p0_rvalid in cycle 3, mem_we=1 in cycle 3, no rvalid in cycle 4.
REQ-035 p0_lock=1 for 4 granted cycles while p1_req=1 -> p1_gnt=0 throughout; p1 is granted in the cycle after p0 drops lock (round-robin build) or per the priority rules (fixed build).
REQ-036 reset asserted in the cycle after a granted p1 read -> p1_rvalid=0, mem_we=0, FSM=ARB; the next request is served normally.
REQ-037 DMEM_ARB_RR_EN defined, both ports requesting for 6 cycles -> grants alternate p0,p1,p0,p1,p0,p1.
